// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the execute-stage multiplier.
//   mul_op_e     RV32M multiply opcode as presented on op_in
//   mul_state_e  sequencing states of mul_seq_ctrl
//   MUL_ITER     number of shift-and-add iterations (one per multiplier bit)
package alu_pkg;

  localparam int MUL_ITER = 32;
  localparam int CNT_W    = $clog2(MUL_ITER);

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    CALC,
    NEG_LO,
    NEG_HI,
    DONE
  } mul_state_e;

  // Multiplicand a is two's complement for MULH and MULHSU.
  function automatic logic op_signed_a(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  // Multiplier b is two's complement for MULH only.
  function automatic logic op_signed_b(input mul_op_e op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/FullAdder16b.sv
// FullAdder16b: 16-bit ripple-carry adder slice.
//   operand1_in  16  first addend
//   operand2_in  16  second addend
//   carry_in      1  carry into bit 0
//   result_out   16  sum
//   carry_out     1  carry out of bit 15
module FullAdder16b (
  input  logic [15:0] operand1_in,
  input  logic [15:0] operand2_in,
  input  logic        carry_in,
  output logic [15:0] result_out,
  output logic        carry_out
);

  logic [16:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign result_out[i] = operand1_in[i] ^ operand2_in[i] ^ carry[i];
    assign carry[i+1]    = (operand1_in[i] & operand2_in[i]) |
                           (carry[i] & (operand1_in[i] ^ operand2_in[i]));
  end

  assign carry_out = carry[16];

endmodule

// File: rtl/adder32.sv
// adder32: 32-bit ripple-carry adder built from two 16-bit slices with the
// carry chained from the low slice into the high slice.
//   operand1_in  32  first addend
//   operand2_in  32  second addend
//   carry_in      1  carry into bit 0
//   result_out   32  sum
//   carry_out     1  carry out of bit 31
module adder32 (
  input  logic [31:0] operand1_in,
  input  logic [31:0] operand2_in,
  input  logic        carry_in,
  output logic [31:0] result_out,
  output logic        carry_out
);

  logic carry_mid;

  FullAdder16b u_lo (
    .operand1_in (operand1_in[15:0]),
    .operand2_in (operand2_in[15:0]),
    .carry_in    (carry_in),
    .result_out  (result_out[15:0]),
    .carry_out   (carry_mid)
  );

  FullAdder16b u_hi (
    .operand1_in (operand1_in[31:16]),
    .operand2_in (operand2_in[31:16]),
    .carry_in    (carry_mid),
    .result_out  (result_out[31:16]),
    .carry_out   (carry_out)
  );

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// One shared 32-bit adder is time-multiplexed through: |a|, |b|, 32 accumulate
// steps, and an optional 64-bit negation done as two 32-bit halves.
//   clk_in          clock, rising edge
//   rst_in          synchronous active-high reset
//   req_valid_in    request present
//   req_ready_out   request accepted when high (IDLE only)
//   op_in           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   operand1_in     rs1, multiplicand a
//   operand2_in     rs2, multiplier b
//   resp_valid_out  result_out valid, held until resp_ready_in
//   resp_ready_in   consumer takes the result
//   result_out      low word (MUL) or high word (others), 0 when not valid
//   busy_out        high whenever not IDLE
module mul_seq_ctrl
  import alu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [1:0]  op_in,
  input  logic [31:0] operand1_in,
  input  logic [31:0] operand2_in,
  output logic        resp_valid_out,
  input  logic        resp_ready_in,
  output logic [31:0] result_out,
  output logic        busy_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  mul_state_e       state_q, state_d;
  mul_op_e          op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_b_q, sign_b_d;
  logic             neg_q, neg_d;
  logic             neg_c_q, neg_c_d;
  logic             resp_valid_q, resp_valid_d;

  logic [31:0]      add_op1, add_op2, add_sum;
  logic             add_cin, add_cout;

  logic             accept;
  mul_op_e          op_in_e;
  logic             sign_a_in, sign_b_in;

  assign op_in_e   = mul_op_e'(op_in);
  assign accept    = req_valid_in && (state_q == IDLE);
  assign sign_a_in = op_signed_a(op_in_e) && operand1_in[31];
  assign sign_b_in = op_signed_b(op_in_e) && operand2_in[31];

  // Adder operand steering: every arithmetic step goes through u_add.
  // Two's complement negation is ~x + 1; the high half of the 64-bit
  // negation takes the carry left over from negating the low half.
  always_comb begin
    add_op1 = '0;
    add_op2 = '0;
    add_cin = 1'b0;
    unique case (state_q)
      ABS_A: begin
        add_op1 = ~a_q;
        add_cin = 1'b1;
      end
      ABS_B, NEG_LO: begin
        add_op1 = ~lo_q;
        add_cin = 1'b1;
      end
      CALC: begin
        add_op1 = hi_q;
        add_op2 = lo_q[0] ? a_q : '0;
      end
      NEG_HI: begin
        add_op1 = ~hi_q;
        add_cin = neg_c_q;
      end
      default: ;
    endcase
  end

  adder32 u_add (
    .operand1_in (add_op1),
    .operand2_in (add_op2),
    .carry_in    (add_cin),
    .result_out  (add_sum),
    .carry_out   (add_cout)
  );

  // Sequencing and datapath register updates.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    sign_b_d     = sign_b_q;
    neg_d        = neg_q;
    neg_c_d      = neg_c_q;
    resp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = op_in_e;
          a_d      = operand1_in;
          lo_d     = operand2_in;
          hi_d     = '0;
          cnt_d    = '0;
          neg_c_d  = 1'b0;
          sign_b_d = sign_b_in;
          // MUL returns the low word, which is identical for signed and
          // unsigned operands, so it never needs the final negation.
          neg_d    = (sign_a_in ^ sign_b_in) && (op_in_e != MUL);
          if (sign_a_in)      state_d = ABS_A;
          else if (sign_b_in) state_d = ABS_B;
          else                state_d = CALC;
        end
      end

      ABS_A: begin
        a_d     = add_sum;
        state_d = sign_b_q ? ABS_B : CALC;
      end

      ABS_B: begin
        lo_d    = add_sum;
        state_d = CALC;
      end

      CALC: begin
        // {hi, lo} holds the partial product above the unconsumed multiplier
        // bits; the 33-bit sum shifts right by one into the pair.
        hi_d  = {add_cout, add_sum[31:1]};
        lo_d  = {add_sum[0], lo_q[31:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = neg_q ? NEG_LO : DONE;
        end
      end

      NEG_LO: begin
        lo_d    = add_sum;
        neg_c_d = add_cout;
        state_d = NEG_HI;
      end

      NEG_HI: begin
        hi_d    = add_sum;
        state_d = DONE;
      end

      DONE: begin
        // First DONE cycle raises the registered valid; the handshake edge
        // clears it and returns to IDLE together.
        if (resp_valid_q && resp_ready_in) begin
          state_d = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      op_q         <= MUL;
      a_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      sign_b_q     <= 1'b0;
      neg_q        <= 1'b0;
      neg_c_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      sign_b_q     <= sign_b_d;
      neg_q        <= neg_d;
      neg_c_q      <= neg_c_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Outputs decode registered state only.
  assign req_ready_out  = (state_q == IDLE);
  assign busy_out       = (state_q != IDLE);
  assign resp_valid_out = resp_valid_q;
  assign result_out     = resp_valid_q ? ((op_q == MUL) ? lo_q : hi_q) : '0;

endmodule
